// File: rtl/io_result_compressor.sv
// Reads a block of result words from RAM, run-length encodes them into {count,value}
// packets and streams them to the IO link; IO_CHECKSUM_EN appends a {0, xor} trailer.
module io_result_compressor #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       length,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_data,
    output logic [CNT_W+DATA_W-1:0] io_data,
    output logic                    io_valid,
    input  logic                    io_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    interrupt,
    input  logic                    int_ack
);

    localparam logic [CNT_W-1:0]  RUN_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_ACC, S_EMIT, S_DONE} state_t;
    // Where EMIT goes after its handshake: keep reading, flush the trailing
    // single-word run, finish (or send trailer), or finish unconditionally.
    typedef enum logic [1:0] {R_READ, R_RUN, R_FINAL, R_DONE} ret_t;

    state_t                    state_q, state_d;
    ret_t                      ret_q, ret_d;
    logic [ADDR_W-1:0]         base_q, base_d, len_q, len_d, idx_q, idx_d;
    logic                      first_q, first_d;
    logic [DATA_W-1:0]         cur_q, cur_d, word_q, word_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W+DATA_W-1:0]   pend_q, pend_d;
    logic                      int_q, int_d;
`ifdef IO_CHECKSUM_EN
    logic [DATA_W-1:0]         csum_q, csum_d;
`endif

    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] idx_inc;
    logic              last;

    assign cnt_inc = cnt_q + CNT_ONE;
    assign idx_inc = idx_q + IDX_ONE;
    assign last    = (idx_inc == len_q);

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        first_d = first_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        word_d  = word_q;
`ifdef IO_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = length;
                    idx_d   = '0;
                    first_d = 1'b1;
                    cur_d   = '0;
                    cnt_d   = '0;
                    ret_d   = R_READ;
`ifdef IO_CHECKSUM_EN
                    csum_d  = '0;
                    if (length == '0) begin
                        ret_d   = R_FINAL;
                        state_d = S_ACC;
                    end else begin
                        state_d = S_READ;
                    end
`else
                    state_d = (length == '0) ? S_DONE : S_READ;
`endif
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                word_d  = mem_data;
`ifdef IO_CHECKSUM_EN
                csum_d  = csum_q ^ mem_data;
`endif
                state_d = S_ACC;
            end
            S_ACC: begin
                if (ret_q == R_RUN) begin
                    pend_d  = {cnt_q, cur_q};
                    ret_d   = R_FINAL;
                    state_d = S_EMIT;
                end
`ifdef IO_CHECKSUM_EN
                else if (ret_q == R_FINAL) begin
                    pend_d  = {{CNT_W{1'b0}}, csum_q};
                    ret_d   = R_DONE;
                    state_d = S_EMIT;
                end
`endif
                else begin
                    idx_d = idx_inc;
                    if (first_q || (word_q == cur_q && cnt_q != RUN_MAX)) begin
                        first_d = 1'b0;
                        cur_d   = word_q;
                        cnt_d   = first_q ? CNT_ONE : cnt_inc;
                        if (last) begin
                            pend_d  = {cnt_d, word_q};
                            ret_d   = R_FINAL;
                            state_d = S_EMIT;
                        end else begin
                            state_d = S_READ;
                        end
                    end else begin
                        // Close the current run; the new word opens the next one.
                        pend_d  = {cnt_q, cur_q};
                        cur_d   = word_q;
                        cnt_d   = CNT_ONE;
                        ret_d   = last ? R_RUN : R_READ;
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (io_ready) begin
                    case (ret_q)
                        R_READ:  state_d = S_READ;
                        R_RUN:   state_d = S_ACC;
`ifdef IO_CHECKSUM_EN
                        R_FINAL: state_d = S_ACC;
`else
                        R_FINAL: state_d = S_DONE;
`endif
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A new set beats a coincident acknowledge.
        int_d = int_q;
        if (state_d == S_DONE && state_q != S_DONE)
            int_d = 1'b1;
        else if (int_ack)
            int_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= R_READ;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            word_q  <= '0;
            int_q   <= 1'b0;
`ifdef IO_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            word_q  <= word_d;
            int_q   <= int_d;
`ifdef IO_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_rd    = (state_q == S_READ);
    assign mem_addr  = mem_rd ? (base_q + idx_q) : '0;
    assign io_valid  = (state_q == S_EMIT);
    assign io_data   = io_valid ? pend_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign interrupt = int_q;

endmodule

// File: tb/tb_io_result_compressor.sv
// Randomized and directed bench for io_result_compressor: two instances (CNT_W=8 and CNT_W=2)
// checked against a queue-based run-length reference model.
module tb_io_result_compressor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, int_ack, io_ready;
    logic [9:0] base_addr, length;
    logic       a_mem_rd, b_mem_rd;
    logic [9:0] a_mem_addr, b_mem_addr;
    logic [7:0] a_mem_data, b_mem_data;
    logic [15:0] a_io_data;
    logic [9:0]  b_io_data;
    logic a_io_valid, b_io_valid, a_busy, b_busy, a_done, b_done, a_int, b_int;

    logic [7:0]  mem [1024];
    int          n_asrt = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    io_result_compressor #(.DATA_W(8), .ADDR_W(10), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr), .length(length),
        .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .io_data(a_io_data), .io_valid(a_io_valid), .io_ready(io_ready),
        .busy(a_busy), .done(a_done), .interrupt(a_int), .int_ack(int_ack));

    io_result_compressor #(.DATA_W(8), .ADDR_W(10), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr), .length(length),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .io_data(b_io_data), .io_valid(b_io_valid), .io_ready(io_ready),
        .busy(b_busy), .done(b_done), .interrupt(b_int), .int_ack(int_ack));

    // RAM returns data one cycle after the read strobe.
    always @(posedge clk) begin
        if (a_mem_rd) a_mem_data <= mem[a_mem_addr];
        if (b_mem_rd) b_mem_data <= mem[b_mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel, output logic v, output logic [31:0] d,
                          output logic dn, output logic bz, output logic it);
        if (sel == 0) begin
            v = a_io_valid; d = {16'd0, a_io_data}; dn = a_done; bz = a_busy; it = a_int;
        end else begin
            v = b_io_valid; d = {22'd0, b_io_data}; dn = b_done; bz = b_busy; it = b_int;
        end
    endtask

    task automatic set_start(input int sel, input logic val);
        if (sel == 0) start_a = val;
        else start_b = val;
    endtask

    // Packets encoded as count*256 + value, which matches {count,value} for both instances.
    task automatic model(input int base, input int len, input int cmax);
        int         c;
        logic [7:0] v, x, w;
        c = 0; v = 0; x = 0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            w = mem[10'(base + i)];
            x = x ^ w;
            if (c > 0 && w == v && c < cmax) c++;
            else begin
                if (c > 0) exp_q.push_back(32'(c * 256 + int'(v)));
                v = w;
                c = 1;
            end
        end
        if (c > 0) exp_q.push_back(32'(c * 256 + int'(v)));
`ifdef IO_CHECKSUM_EN
        exp_q.push_back({24'd0, x});
`endif
    endtask

    task automatic xfer(input int sel, input int base, input int len, input int stall,
                        input bit extra, input bit ack);
        logic        v, dn, bz, it;
        logic [31:0] d, pd;
        bit          pv, pr, seen, ex_done;
        int          sc, cyc;
        pd = 0; pv = 0; pr = 0; seen = 0; ex_done = 0; sc = 0; cyc = 0;
        model(base, len, (sel == 0) ? 255 : 3);
        got_q.delete();
        @(negedge clk);
        base_addr = 10'(base);
        length    = 10'(len);
        io_ready  = (stall == 0);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        while (!seen && cyc < 5000) begin
            sample(sel, v, d, dn, bz, it);
            if (dn) begin
                seen = 1;
                chk("int_with_done", 32'(it), 1);
`ifndef IO_CHECKSUM_EN
                if (len == 0) chk("len0_latency", 32'(cyc <= 1), 1);
`endif
            end else begin
                if (pv && pr) chk("no_back_to_back", 32'(v), 0);
                if (v) begin
                    if (pv && !pr) chk("stall_stable", d, pd);
                    else sc = 0;
                    if (sc >= stall) begin
                        io_ready = 1'b1;
                        got_q.push_back(d);
                    end else begin
                        io_ready = 1'b0;
                        sc++;
                        if (extra && !ex_done) begin
                            set_start(sel, 1'b1);
                            base_addr = 10'(base + 50);
                            length    = 10'd3;
                            ex_done   = 1;
                        end
                    end
                end else begin
                    io_ready = (stall == 0);
                end
                pv = v; pr = io_ready; pd = d;
                @(negedge clk);
                set_start(sel, 1'b0);
                cyc++;
            end
        end
        chk("done_seen", 32'(seen), 1);
        chk("pkt_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("pkt%0d", i), got_q[i], exp_q[i]);
        @(negedge clk);
        sample(sel, v, d, dn, bz, it);
        chk("done_one_cycle", 32'(dn), 0);
        chk("idle_after_done", 32'(bz), 0);
        chk("int_held", 32'(it), 1);
        if (ack) begin
            int_ack = 1'b1;
            @(negedge clk);
            int_ack = 1'b0;
            sample(sel, v, d, dn, bz, it);
            chk("int_ack_clear", 32'(it), 0);
        end
        io_ready = 1'b1;
    endtask

    initial begin
        int w;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; int_ack = 1'b0; io_ready = 1'b1;
        base_addr = '0; length = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(a_io_valid), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_int", 32'(a_int), 0);
        chk("rst_mem_rd", 32'(a_mem_rd), 0);
        chk("rst_io_data", 32'(a_io_data), 0);
        chk("rst_mem_addr", 32'(a_mem_addr), 0);
        chk("rst_busy_b", 32'(b_busy), 0);
        rst = 1'b0;

        mem[0] = 8'd5; mem[1] = 8'd5; mem[2] = 8'd5;
        mem[3] = 8'd7; mem[4] = 8'd7; mem[5] = 8'd5;
        xfer(0, 0, 6, 0, 0, 1);                 // basic stream
        xfer(0, 0, 0, 0, 0, 1);                 // empty block
        for (int i = 0; i < 7; i++) mem[20 + i] = 8'h2A;
        xfer(1, 20, 7, 0, 0, 1);                // RUN_MAX=3 splitting
        xfer(0, 0, 6, 5, 0, 1);                 // stalled handshakes
        xfer(0, 0, 6, 2, 1, 1);                 // start while busy is ignored
        for (int i = 0; i < 300; i++) mem[200 + i] = 8'h11;
        xfer(0, 200, 300, 0, 0, 1);             // RUN_MAX=255 splitting
        for (int i = 0; i < 10; i++) mem[10'(1020 + i)] = 8'($urandom_range(0, 1));
        xfer(0, 1020, 10, 1, 0, 1);             // address wrap

        for (int t = 0; t < 8; t++) begin
            int b, l;
            b = $urandom_range(0, 1023);
            l = $urandom_range(1, 40);
            for (int i = 0; i < l; i++) mem[10'(b + i)] = 8'($urandom_range(0, 2)) + 8'h40;
            xfer(t % 2, b, l, $urandom_range(0, 3), 0, 1);
        end

        // Reset in the middle of EMIT with the interrupt still pending.
        xfer(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        base_addr = 10'd0; length = 10'd6; io_ready = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        w = 0;
        while (!a_io_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("reach_emit", 32'(a_io_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_valid", 32'(a_io_valid), 0);
        chk("midrst_int", 32'(a_int), 0);
        rst = 1'b0;
        io_ready = 1'b1;
        xfer(0, 0, 6, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
